cluster_load_ctrl: RTL and testbench

CLUSTER_LOAD_CTRL -- requirements
Module: cluster_load_ctrl

---
 rtl/cluster_ctrl_pkg.sv | 24 ++
 rtl/cluster_load_ctrl_if.sv | 30 +++
 rtl/cluster_load_ctrl_strobe_counter.sv | 23 ++
 rtl/cluster_load_ctrl.sv | 131 +++++++++++++
 tb/tb_cluster_load_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cluster_ctrl_pkg.sv
// Shared types and phase-length helpers for the cluster load controller.
//   state_e        : controller FSM states
//   wght_words()   : weight words loaded per pass (KERNEL_SIZE squared)
//   act_words()    : activation words loaded per pass (ACT_SIZE squared)
//   strobe_cnt_w() : counter width able to hold the larger of the two
package cluster_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_A, COMPUTE, ERR} state_e;

  function automatic int wght_words(input int k);
    return k * k;
  endfunction

  function automatic int act_words(input int a);
    return a * a;
  endfunction

  function automatic int strobe_cnt_w(input int k, input int a);
    int m;
    m = (k * k > a * a) ? k * k : a * a;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cluster_load_ctrl_if.sv
// Handshake bundle between the load controller and its environment
// (job requester, weight/ifmap routers, PE array).
//   master : controller side (drives spad load commands, pe_start, status)
//   slave  : environment side (drives start/num_pass and router/PE strobes)
interface cluster_load_ctrl_if #(
  parameter int PASS_BITS = 8
) ();
  logic                 start;
  logic [PASS_BITS-1:0] num_pass;
  logic                 load_spad_wght;
  logic                 wght_load_en;
  logic                 load_spad_act;
  logic                 act_load_en;
  logic                 pe_start;
  logic                 pe_done;
  logic                 busy;
  logic                 done;
  logic [PASS_BITS-1:0] pass_cnt;
  logic                 error;

  modport master (
    input  start, num_pass, wght_load_en, act_load_en, pe_done,
    output load_spad_wght, load_spad_act, pe_start, busy, done, pass_cnt, error
  );

  modport slave (
    output start, num_pass, wght_load_en, act_load_en, pe_done,
    input  load_spad_wght, load_spad_act, pe_start, busy, done, pass_cnt, error
  );
endinterface

// File: rtl/cluster_load_ctrl_strobe_counter.sv
// strobe_counter: counts enable strobes up to TARGET.
//   clk, reset : clock, synchronous active-high reset
//   en         : strobe, already qualified by the owning phase
//   hit        : combinational, high on the strobe that completes TARGET
// The counter clears itself on hit, so it never exceeds TARGET-1 and cannot wrap.
module strobe_counter #(
  parameter int TARGET = 9,
  parameter int CNT_W  = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic hit
);
  logic [CNT_W-1:0] count;

  assign hit = en && (count == CNT_W'(TARGET - 1));

  always_ff @(posedge clk) begin
    if (reset || hit) count <= '0;
    else if (en)      count <= count + 1'b1;
  end
endmodule

// File: rtl/cluster_load_ctrl.sv
// cluster_load_ctrl: sequences weight load, activation load and PE compute
// for num_pass passes per job.
//   clk, reset : clock, synchronous active-high reset
//   bus        : cluster_load_ctrl_if.master (start/num_pass in, spad load
//                pulses, pe_start, busy/done/pass_cnt/error out)
// Optional build macro LOAD_CTRL_TIMEOUT_EN: per-phase watchdog; a phase that
// lasts TIMEOUT_CYCLES cycles parks the FSM in ERR with a sticky error flag.
// Without it, error is tied low and ERR is never entered.
module cluster_load_ctrl
  import cluster_ctrl_pkg::*;
#(
  parameter int KERNEL_SIZE    = 3,
  parameter int ACT_SIZE       = 5,
  parameter int PASS_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 reset,
  cluster_load_ctrl_if.master bus
);
  localparam int CNT_W = strobe_cnt_w(KERNEL_SIZE, ACT_SIZE);

  state_e               state, state_nxt;
  logic [PASS_BITS-1:0] num_pass_q, pass_cnt_q, pass_cnt_nxt;
  logic                 ldw_q, lda_q, pes_q, done_q, busy_q;
  logic                 ldw_nxt, lda_nxt, pes_nxt, done_nxt;
  logic                 w_hit, a_hit, tmo;

  // Strobes are only seen by a counter while its phase is active.
  strobe_counter #(.TARGET(wght_words(KERNEL_SIZE)), .CNT_W(CNT_W)) u_wcnt (
    .clk(clk), .reset(reset), .en(bus.wght_load_en && state == LOAD_W), .hit(w_hit)
  );
  strobe_counter #(.TARGET(act_words(ACT_SIZE)), .CNT_W(CNT_W)) u_acnt (
    .clk(clk), .reset(reset), .en(bus.act_load_en && state == LOAD_A), .hit(a_hit)
  );

`ifdef LOAD_CTRL_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr;
  logic             err_q;
  logic             in_phase;

  assign in_phase = (state == LOAD_W) || (state == LOAD_A) || (state == COMPUTE);
  assign tmo      = in_phase && (tmr == TMR_W'(TIMEOUT_CYCLES - 1));

  // Any state change restarts the count, so each phase gets a fresh budget.
  always_ff @(posedge clk) begin
    if (reset || state_nxt != state) tmr <= '0;
    else if (in_phase)               tmr <= tmr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= (state_nxt == ERR);
  end
  assign bus.error = err_q;
`else
  assign tmo       = 1'b0;
  assign bus.error = 1'b0;
`endif

  // Phase completion takes priority over a watchdog expiring in the same cycle.
  always_comb begin
    state_nxt    = state;
    pass_cnt_nxt = pass_cnt_q;
    ldw_nxt      = 1'b0;
    lda_nxt      = 1'b0;
    pes_nxt      = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        pass_cnt_nxt = '0;
        if (bus.num_pass != '0) begin
          state_nxt = LOAD_W;
          ldw_nxt   = 1'b1;
        end else begin
          done_nxt = 1'b1;
        end
      end
      LOAD_W: if (w_hit) begin
        state_nxt = LOAD_A;
        lda_nxt   = 1'b1;
      end else if (tmo) state_nxt = ERR;
      LOAD_A: if (a_hit) begin
        state_nxt = COMPUTE;
        pes_nxt   = 1'b1;
      end else if (tmo) state_nxt = ERR;
      COMPUTE: if (bus.pe_done) begin
        pass_cnt_nxt = pass_cnt_q + 1'b1;
        if (pass_cnt_nxt == num_pass_q) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = LOAD_W;
          ldw_nxt   = 1'b1;
        end
      end else if (tmo) state_nxt = ERR;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      num_pass_q <= '0;
      pass_cnt_q <= '0;
      ldw_q      <= 1'b0;
      lda_q      <= 1'b0;
      pes_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pass_cnt_q <= pass_cnt_nxt;
      if (state == IDLE && bus.start) num_pass_q <= bus.num_pass;
      ldw_q      <= ldw_nxt;
      lda_q      <= lda_nxt;
      pes_q      <= pes_nxt;
      done_q     <= done_nxt;
      busy_q     <= (state_nxt != IDLE);
    end
  end

  assign bus.load_spad_wght = ldw_q;
  assign bus.load_spad_act  = lda_q;
  assign bus.pe_start       = pes_q;
  assign bus.done           = done_q;
  assign bus.busy           = busy_q;
  assign bus.pass_cnt       = pass_cnt_q;
endmodule

// File: tb/tb_cluster_load_ctrl.sv
// Self-checking bench for cluster_load_ctrl. Expected pulses are queued as
// stimulus is driven; a negedge monitor pops and compares them as the DUT
// emits load_spad_wght / load_spad_act / pe_start / done.
module tb_cluster_load_ctrl;
`ifdef LOAD_CTRL_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  localparam int NW = 9;
  localparam int NA = 25;

  localparam int EV_LDW  = 1;
  localparam int EV_LDA  = 2;
  localparam int EV_PES  = 3;
  localparam int EV_DONE = 4;
  localparam int EV_NONE = 0;

  typedef struct {
    int         kind;
    logic [7:0] pc;
    bit         chk_pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  cluster_load_ctrl_if #(.PASS_BITS(8)) bus ();

  cluster_load_ctrl #(
    .KERNEL_SIZE(3), .ACT_SIZE(5), .PASS_BITS(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [7:0] pc, input bit chk_pc);
    exp_t e;
    e.kind = kind; e.pc = pc; e.chk_pc = chk_pc;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected", kind, EV_NONE);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", kind, e.kind);
      if (e.chk_pc) chk("sb_pass_cnt", bus.pass_cnt, e.pc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.load_spad_wght) sb_pop(EV_LDW);
      if (bus.load_spad_act)  sb_pop(EV_LDA);
      if (bus.pe_start)       sb_pop(EV_PES);
      if (bus.done)           sb_pop(EV_DONE);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_error"}, bus.error, 0);
    chk({tag, "_pass_cnt"}, bus.pass_cnt, 0);
    chk({tag, "_ldw"}, bus.load_spad_wght, 0);
    chk({tag, "_lda"}, bus.load_spad_act, 0);
    chk({tag, "_pes"}, bus.pe_start, 0);
  endtask

  // One job of n passes. stray: inject start/pe_done/act strobes mid LOAD_W.
  // abort: assert reset after 4 activation strobes of the first pass.
  task automatic job(input int n, input bit stray, input bit abort);
    push(EV_LDW, 8'd0, 1'b0);
    bus.num_pass = n[7:0];
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_ldw", bus.load_spad_wght, 1);
    for (int p = 0; p < n; p++) begin
      for (int s = 0; s < NW; s++) begin
        if (stray && p == 0 && s == 4) begin
          bus.start = 1'b1; bus.num_pass = 8'd7;
          bus.pe_done = 1'b1; bus.act_load_en = 1'b1;
          tick(); tick();
          bus.start = 1'b0; bus.pe_done = 1'b0; bus.act_load_en = 1'b0;
          bus.num_pass = 8'd0;
          chk("stray_busy", bus.busy, 1);
          chk("stray_pass_cnt", bus.pass_cnt, p);
        end
        if ($urandom_range(0, 2) == 0) tick();
        chk("lda_early", bus.load_spad_act, 0);
        if (s == NW - 1) push(EV_LDA, 8'd0, 1'b0);
        bus.wght_load_en = 1'b1; tick(); bus.wght_load_en = 1'b0;
      end
      chk("lda", bus.load_spad_act, 1);
      for (int s = 0; s < NA; s++) begin
        if (abort && p == 0 && s == 4) begin
          reset = 1'b1;
          tick();
          chk_all_zero("midreset");
          reset = 1'b0;
          return;
        end
        if ($urandom_range(0, 3) == 0) tick();
        chk("pes_early", bus.pe_start, 0);
        if (s == NA - 1) push(EV_PES, 8'd0, 1'b0);
        bus.act_load_en = 1'b1; tick(); bus.act_load_en = 1'b0;
      end
      chk("pes", bus.pe_start, 1);
      tick(); tick();
      chk("compute_busy", bus.busy, 1);
      if (p == n - 1) push(EV_DONE, n[7:0], 1'b1);
      else            push(EV_LDW, 8'd0, 1'b0);
      bus.pe_done = 1'b1; tick(); bus.pe_done = 1'b0;
      chk("pass_cnt", bus.pass_cnt, p + 1);
      if (p == n - 1) begin
        chk("done", bus.done, 1);
        chk("done_busy", bus.busy, 0);
      end else begin
        chk("next_ldw", bus.load_spad_wght, 1);
      end
    end
    tick(); tick();
    chk("hold_pass_cnt", bus.pass_cnt, n);
    chk("hold_done", bus.done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.start = 1'b0; bus.num_pass = '0; bus.wght_load_en = 1'b0;
    bus.act_load_en = 1'b0; bus.pe_done = 1'b0;
    reset = 1'b1;
    tick(); tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
`ifdef LOAD_CTRL_TIMEOUT_EN
    // No weight strobes: watchdog trips after 16 cycles in LOAD_W.
    push(EV_LDW, 8'd0, 1'b0);
    bus.num_pass = 8'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("tmo_quiet", bus.error, 0);
      tick();
    end
    chk("tmo_error", bus.error, 1);
    chk("tmo_busy", bus.busy, 1);
    for (int k = 0; k < 12; k++) begin
      bus.start = 1'b1; bus.wght_load_en = 1'b1; bus.pe_done = 1'b1;
      tick();
      chk("err_sticky", bus.error, 1);
      chk("err_busy", bus.busy, 1);
    end
    bus.start = 1'b0; bus.wght_load_en = 1'b0; bus.pe_done = 1'b0;
    reset = 1'b1;
    tick();
    chk_all_zero("err_reset");
    reset = 1'b0;
    tick();
    chk("err_reset_idle", bus.busy, 0);
`else
    // Start accepted in the first cycle out of reset.
    job(1, 1'b0, 1'b0);
    job(3, 1'b0, 1'b0);
    // Zero-pass job: done next cycle, never busy, no load pulses.
    push(EV_DONE, 8'd0, 1'b0);
    bus.num_pass = 8'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("zero_done", bus.done, 1);
    chk("zero_busy", bus.busy, 0);
    chk("zero_ldw", bus.load_spad_wght, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("zero_idle_busy", bus.busy, 0);
      chk("zero_idle_done", bus.done, 0);
    end
    job(2, 1'b1, 1'b0);
    job(2, 1'b0, 1'b1);
    job(1, 1'b0, 1'b0);
    tick();
    chk("final_error", bus.error, 0);
`endif
    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
